// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, arbiter FSM state
// and the fixed dcache-over-icache priority rule.
package cpu_types_pkg;

   localparam int unsigned AddrWidth  = 32;
   localparam int unsigned DataWidth  = 32;
   localparam int unsigned CountWidth = 32;

   typedef enum logic [1:0] {
      RamFree   = 2'd0,
      RamBusy   = 2'd1,
      RamAccess = 2'd2,
      RamError  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDgnt = 2'd1,
      StIgnt = 2'd2
   } arb_state_t;

   // dcache always wins; used from IDLE and again right after a completion
   function automatic arb_state_t arbitrate(input logic dreq, input logic ireq);
      if (dreq) begin
         return StDgnt;
      end else if (ireq) begin
         return StIgnt;
      end
      return StIdle;
   endfunction

endpackage

// File: rtl/access_counter.sv
// Completed-access counter: synchronous clear, count enable, wraps modulo 2^Width.
module access_counter
   import cpu_types_pkg::*;
#(
   parameter int unsigned Width = CountWidth
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + Width'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter in front of a single RAM; dcache has strict
// priority and keeps the bus across back-to-back requests.
module mem_arbiter
   import cpu_types_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   // icache
   input  logic                  iREN,
   input  logic [AddrWidth-1:0]  iaddr,
   output logic [DataWidth-1:0]  iload,
   output logic                  iwait,
   // dcache
   input  logic                  dREN,
   input  logic                  dWEN,
   input  logic [AddrWidth-1:0]  daddr,
   input  logic [DataWidth-1:0]  dstore,
   output logic [DataWidth-1:0]  dload,
   output logic                  dwait,
   // RAM
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [AddrWidth-1:0]  ramaddr,
   output logic [DataWidth-1:0]  ramstore,
   input  logic [DataWidth-1:0]  ramload,
   input  logic [1:0]            ramstate,
   // status
   output logic [CountWidth-1:0] icount,
   output logic [CountWidth-1:0] dcount,
   output logic                  ramerr
);

   arb_state_t state_q;
   logic       ramerr_q;
   ramstate_t  rs;
   logic       dreq, ireq;
   logic       ram_acc, ram_err;
   logic       d_done, i_done, grant_err;

   assign rs      = ramstate_t'(ramstate);
   assign dreq    = dREN | dWEN;
   assign ireq    = iREN;
   assign ram_acc = (rs == RamAccess);
   assign ram_err = (rs == RamError);

   // A completion needs the granted side to still be requesting
   assign d_done    = (state_q == StDgnt) & dreq & ram_acc;
   assign i_done    = (state_q == StIgnt) & ireq & ram_acc;
   assign grant_err = ram_err & (((state_q == StDgnt) & dreq) | ((state_q == StIgnt) & ireq));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         ramerr_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: state_q <= arbitrate(dreq, ireq);
            StDgnt: begin
               if (!dreq) begin
                  state_q <= StIdle;
               end else if (d_done) begin
                  state_q <= arbitrate(dreq, ireq);
               end
            end
            StIgnt: begin
               if (!ireq) begin
                  state_q <= StIdle;
               end else if (i_done) begin
                  state_q <= arbitrate(dreq, ireq);
               end
            end
            default: state_q <= StIdle;
         endcase
         if (grant_err) begin
            ramerr_q <= 1'b1;
         end
      end
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = ireq;
      dwait    = dreq;
      case (state_q)
         StDgnt: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dwait    = dreq & ~ram_acc;
            if (d_done && !dWEN) begin
               dload = ramload;
            end
         end
         StIgnt: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            iwait   = ireq & ~ram_acc;
            if (i_done) begin
               iload = ramload;
            end
         end
         default: ;
      endcase
   end

   assign ramerr = ramerr_q;

   access_counter #(
      .Width (CountWidth)
   ) u_icount (
      .clk_i   (CLK),
      .clr_i   (RST),
      .en_i    (i_done),
      .count_o (icount)
   );

   access_counter #(
      .Width (CountWidth)
   ) u_dcount (
      .clk_i   (CLK),
      .clr_i   (RST),
      .en_i    (d_done),
      .count_o (dcount)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter with a read-data scoreboard.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam logic [1:0] Fre = 2'd0;
   localparam logic [1:0] Bsy = 2'd1;
   localparam logic [1:0] Acc = 2'd2;
   localparam logic [1:0] Err = 2'd3;

   typedef struct {
      logic        rst, ir, dr, dw;
      logic [31:0] ia, da, ds;
      logic [1:0]  rs;
      logic [31:0] rl;
      logic        eren, ewen;
      logic [31:0] eaddr, estore;
      logic        eiw, edw;
      logic [31:0] eil, edl;
      logic        eerr;
      logic [31:0] eic, edc;
      logic [1:0]  sb;  // 1: dcache read completes this cycle, 2: icache
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount;
   logic        iwait, dwait, ramREN, ramWEN, ramerr;

   int checks   = 0;
   int failures = 0;
   logic [31:0] dq[$];
   logic [31:0] iq[$];
   vec_t tbl[$];

   always #5 CLK = ~CLK;

   mem_arbiter dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iload    (iload),
      .iwait    (iwait),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dload    (dload),
      .dwait    (dwait),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .icount   (icount),
      .dcount   (dcount),
      .ramerr   (ramerr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic rst, ir, dr, dw, input logic [31:0] ia, da, ds,
      input logic [1:0] rs, input logic [31:0] rl,
      input logic eren, ewen, input logic [31:0] eaddr, estore,
      input logic eiw, edw, input logic [31:0] eil, edl,
      input logic eerr, input logic [31:0] eic, edc, input logic [1:0] sb);
      vec_t v;
      v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw;
      v.ia = ia; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
      v.eren = eren; v.ewen = ewen; v.eaddr = eaddr; v.estore = estore;
      v.eiw = eiw; v.edw = edw; v.eil = eil; v.edl = edl;
      v.eerr = eerr; v.eic = eic; v.edc = edc; v.sb = sb;
      return v;
   endfunction

   // Entered just after a rising edge; leaves just after the next one
   task automatic step(input vec_t v, input string nm);
      RST = v.rst; iREN = v.ir; dREN = v.dr; dWEN = v.dw;
      iaddr = v.ia; daddr = v.da; dstore = v.ds; ramstate = v.rs; ramload = v.rl;
      if (v.sb == 2'd1) dq.push_back(v.rl);
      if (v.sb == 2'd2) iq.push_back(v.rl);
      @(negedge CLK);
      chk({nm, "_ramREN"},   32'(ramREN),   32'(v.eren));
      chk({nm, "_ramWEN"},   32'(ramWEN),   32'(v.ewen));
      chk({nm, "_ramaddr"},  ramaddr,       v.eaddr);
      chk({nm, "_ramstore"}, ramstore,      v.estore);
      chk({nm, "_iwait"},    32'(iwait),    32'(v.eiw));
      chk({nm, "_dwait"},    32'(dwait),    32'(v.edw));
      chk({nm, "_iload"},    iload,         v.eil);
      chk({nm, "_dload"},    dload,         v.edl);
      chk({nm, "_ramerr"},   32'(ramerr),   32'(v.eerr));
      chk({nm, "_icount"},   icount,        v.eic);
      chk({nm, "_dcount"},   dcount,        v.edc);
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard: any visible read completion must match the next queued word
   always @(negedge CLK) begin
      if (dREN && !dWEN && !dwait) begin
         if (dq.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_dload: got unexpected completion %h required none", dload);
         end else begin
            chk("sb_dload", dload, dq.pop_front());
         end
      end
      if (iREN && !iwait) begin
         if (iq.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_iload: got unexpected completion %h required none", iload);
         end else begin
            chk("sb_iload", iload, iq.pop_front());
         end
      end
   end

   initial begin
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramstate = Fre; ramload = 0;

      // idle after reset, then simultaneous request with two BUSY cycles
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0));
      tbl.push_back(mk(0,1,1,0, 0,32'h100,0, Fre,0, 0,0, 0,0, 1,1, 0,0, 0, 0,0, 0));
      tbl.push_back(mk(0,1,1,0, 0,32'h100,0, Bsy,32'h11111111, 1,0, 32'h100,0, 1,1, 0,0,
                       0, 0,0, 0));
      tbl.push_back(mk(0,1,1,0, 0,32'h100,0, Bsy,32'h11111111, 1,0, 32'h100,0, 1,1, 0,0,
                       0, 0,0, 0));
      tbl.push_back(mk(0,1,1,0, 0,32'h100,0, Acc,32'hA5A50100, 1,0, 32'h100,0, 1,0,
                       0,32'hA5A50100, 0, 0,0, 1));
      tbl.push_back(mk(0,1,0,0, 0,0,0, Fre,0, 0,0, 0,0, 1,0, 0,0, 0, 0,1, 0));
      tbl.push_back(mk(0,1,0,0, 0,0,0, Fre,0, 0,0, 0,0, 1,0, 0,0, 0, 0,1, 0));
      tbl.push_back(mk(0,1,0,0, 0,0,0, Bsy,0, 1,0, 0,0, 1,0, 0,0, 0, 0,1, 0));
      tbl.push_back(mk(0,1,0,0, 0,0,0, Acc,32'h0BADF00D, 1,0, 0,0, 0,0, 32'h0BADF00D,0,
                       0, 0,1, 2));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 1,1, 0));
      // write wins over simultaneous read
      tbl.push_back(mk(0,0,1,1, 0,32'h300,32'hDEADBEEF, Fre,0, 0,0, 0,0, 0,1, 0,0,
                       0, 1,1, 0));
      tbl.push_back(mk(0,0,1,1, 0,32'h300,32'hDEADBEEF, Bsy,0, 0,1, 32'h300,32'hDEADBEEF,
                       0,1, 0,0, 0, 1,1, 0));
      tbl.push_back(mk(0,0,1,1, 0,32'h300,32'hDEADBEEF, Acc,32'h12345678, 0,1, 32'h300,
                       32'hDEADBEEF, 0,0, 0,0, 0, 1,1, 0));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 1,2, 0));
      // dcache arrives during IGNT: waits, then takes the bus after completion
      tbl.push_back(mk(0,1,0,0, 32'h40,0,0, Fre,0, 0,0, 0,0, 1,0, 0,0, 0, 1,2, 0));
      tbl.push_back(mk(0,1,1,0, 32'h40,32'h500,0, Bsy,0, 1,0, 32'h40,0, 1,1, 0,0,
                       0, 1,2, 0));
      tbl.push_back(mk(0,1,1,0, 32'h40,32'h500,0, Acc,32'hCAFE0040, 1,0, 32'h40,0, 0,1,
                       32'hCAFE0040,0, 0, 1,2, 2));
      tbl.push_back(mk(0,0,1,0, 32'h40,32'h500,0, Acc,32'h00000500, 1,0, 32'h500,0, 0,0,
                       0,32'h500, 0, 2,2, 1));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 2,3, 0));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 2,3, 0));
      // icache abandons its request before ACCESS; ACCESS in IDLE is ignored
      tbl.push_back(mk(0,1,0,0, 32'h80,0,0, Fre,0, 0,0, 0,0, 1,0, 0,0, 0, 2,3, 0));
      tbl.push_back(mk(0,1,0,0, 32'h80,0,0, Bsy,0, 1,0, 32'h80,0, 1,0, 0,0, 0, 2,3, 0));
      tbl.push_back(mk(0,0,0,0, 32'h80,0,0, Fre,0, 0,0, 32'h80,0, 0,0, 0,0, 0, 2,3, 0));
      tbl.push_back(mk(0,0,0,0, 32'h80,0,0, Acc,0, 0,0, 0,0, 0,0, 0,0, 0, 2,3, 0));
      // two-word burst keeps the bus with iREN held
      tbl.push_back(mk(0,1,1,0, 32'h44,32'h200,0, Fre,0, 0,0, 0,0, 1,1, 0,0, 0, 2,3, 0));
      tbl.push_back(mk(0,1,1,0, 32'h44,32'h200,0, Bsy,0, 1,0, 32'h200,0, 1,1, 0,0,
                       0, 2,3, 0));
      tbl.push_back(mk(0,1,1,0, 32'h44,32'h200,0, Acc,32'h20000001, 1,0, 32'h200,0, 1,0,
                       0,32'h20000001, 0, 2,3, 1));
      tbl.push_back(mk(0,1,1,0, 32'h44,32'h204,0, Bsy,0, 1,0, 32'h204,0, 1,1, 0,0,
                       0, 2,4, 0));
      tbl.push_back(mk(0,1,1,0, 32'h44,32'h204,0, Acc,32'h20000002, 1,0, 32'h204,0, 1,0,
                       0,32'h20000002, 0, 2,4, 1));
      tbl.push_back(mk(0,1,0,0, 32'h44,0,0, Fre,0, 0,0, 0,0, 1,0, 0,0, 0, 2,5, 0));
      tbl.push_back(mk(0,1,0,0, 32'h44,0,0, Fre,0, 0,0, 0,0, 1,0, 0,0, 0, 2,5, 0));
      tbl.push_back(mk(0,0,0,0, 32'h44,0,0, Fre,0, 0,0, 32'h44,0, 0,0, 0,0, 0, 2,5, 0));
      // ERROR for three cycles, then ACCESS; flag stays set
      tbl.push_back(mk(0,0,1,0, 0,32'h700,0, Fre,0, 0,0, 0,0, 0,1, 0,0, 0, 2,5, 0));
      tbl.push_back(mk(0,0,1,0, 0,32'h700,0, Err,0, 1,0, 32'h700,0, 0,1, 0,0, 0, 2,5, 0));
      tbl.push_back(mk(0,0,1,0, 0,32'h700,0, Err,0, 1,0, 32'h700,0, 0,1, 0,0, 1, 2,5, 0));
      tbl.push_back(mk(0,0,1,0, 0,32'h700,0, Err,0, 1,0, 32'h700,0, 0,1, 0,0, 1, 2,5, 0));
      tbl.push_back(mk(0,0,1,0, 0,32'h700,0, Acc,32'h77770000, 1,0, 32'h700,0, 0,0,
                       0,32'h77770000, 1, 2,5, 1));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 1, 2,6, 0));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 1, 2,6, 0));
      // reset while DGNT/BUSY on a write
      tbl.push_back(mk(0,0,1,1, 0,32'h800,32'h5555AAAA, Fre,0, 0,0, 0,0, 0,1, 0,0,
                       1, 2,6, 0));
      tbl.push_back(mk(0,0,1,1, 0,32'h800,32'h5555AAAA, Bsy,0, 0,1, 32'h800,32'h5555AAAA,
                       0,1, 0,0, 1, 2,6, 0));
      tbl.push_back(mk(1,0,1,1, 0,32'h800,32'h5555AAAA, Bsy,0, 0,1, 32'h800,32'h5555AAAA,
                       0,1, 0,0, 1, 2,6, 0));
      tbl.push_back(mk(0,0,1,1, 0,32'h800,32'h5555AAAA, Bsy,0, 0,0, 0,0, 0,1, 0,0,
                       0, 0,0, 0));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0));
      tbl.push_back(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0));

      repeat (2) @(posedge CLK);
      #1;
      foreach (tbl[i]) step(tbl[i], $sformatf("r%0d", i));

      // Reset coinciding with a completion: reset wins, no count
      step(mk(0,0,1,0, 0,32'h900,0, Fre,0, 0,0, 0,0, 0,1, 0,0, 0, 0,0, 0), "rstacc0");
      step(mk(1,0,1,0, 0,32'h900,0, Acc,32'h99990000, 1,0, 32'h900,0, 0,0,
              0,32'h99990000, 0, 0,0, 1), "rstacc1");
      step(mk(0,0,1,0, 0,32'h900,0, Fre,0, 0,0, 0,0, 0,1, 0,0, 0, 0,0, 0), "rstacc2");
      step(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0), "rstacc3");
      step(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0), "rstacc4");

      // dcount wraps from all-ones to zero
      force dut.u_dcount.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_dcount.count_q;
      step(mk(0,0,1,0, 0,32'hA00,0, Fre,0, 0,0, 0,0, 0,1, 0,0, 0, 0,32'hFFFFFFFF, 0),
           "wrap0");
      step(mk(0,0,1,0, 0,32'hA00,0, Acc,32'hAAAA0000, 1,0, 32'hA00,0, 0,0,
              0,32'hAAAA0000, 0, 0,32'hFFFFFFFF, 1), "wrap1");
      step(mk(0,0,0,0, 0,0,0, Fre,0, 0,0, 0,0, 0,0, 0,0, 0, 0,0, 0), "wrap2");

      chk("sb_dq_drained", 32'(dq.size()), 32'd0);
      chk("sb_iq_drained", 32'(iq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
